// File: rtl/pc_if.sv
// pc_if: fetch-control bundle between the datapath and pc_sequencer.
//   master (datapath/bench) drives stall, imem_ready, branch_taken, jump, PCBranch, instr_index
//   and reads PC, PCPlus4, fetch_valid, misalign; slave (pc_sequencer) is the reverse.
interface pc_if;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic        jump;
  logic [31:0] PCBranch;
  logic [25:0] instr_index;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_valid;
  logic        misalign;
  modport master (output stall, imem_ready, branch_taken, jump, PCBranch, instr_index,
                  input PC, PCPlus4, fetch_valid, misalign);
  modport slave (input stall, imem_ready, branch_taken, jump, PCBranch, instr_index,
                 output PC, PCPlus4, fetch_valid, misalign);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and next-PC select that holds across stalls/imem wait, buffering the redirect.
//   Ports: clk, rst_n (async active-low), bus (pc_if.slave: control inputs in; PC, PCPlus4, fetch_valid, misalign out).
//   Optional macro MISALIGN_TRAP_EN: a misaligned loaded target jumps to TRAP_VECTOR with a one-cycle misalign pulse;
//   without it, bits [1:0] of every loaded PC are cleared and misalign is tied 0.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h8000_0180
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);
  localparam logic [1:0] RESET_HOLD = 2'b00, RUN = 2'b01, HOLD = 2'b10;
  logic [1:0] state;
  logic [31:0] pc, pend_pc, next_pc, load_pc;
  logic advance, fv;
  assign bus.PC = pc;
  assign bus.PCPlus4 = pc + 32'd4;
  assign bus.fetch_valid = fv;
  assign advance = ~bus.stall & bus.imem_ready;
  always_comb begin
    next_pc = bus.jump ? {bus.PCPlus4[31:28], bus.instr_index, 2'b00} : bus.branch_taken ? bus.PCBranch : bus.PCPlus4;
    load_pc = state == HOLD ? pend_pc : next_pc;
  end
`ifdef MISALIGN_TRAP_EN
  logic mis, trap;
  assign trap = |load_pc[1:0];
  assign bus.misalign = mis;
`else
  assign bus.misalign = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_VECTOR;
      state <= RESET_HOLD;
      pend_pc <= '0;
      fv <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis <= 1'b0;
`endif
    end else begin
`ifdef MISALIGN_TRAP_EN
      mis <= 1'b0;
`endif
      case (state)
        RESET_HOLD: begin
          state <= RUN;
          fv <= 1'b1;
        end
        RUN, HOLD:
          if (advance) begin
`ifdef MISALIGN_TRAP_EN
            pc <= trap ? TRAP_VECTOR : load_pc;
            mis <= trap;
`else
            pc <= load_pc & ~32'd3;
`endif
            state <= RUN;
          end else if (state == RUN) begin
            // redirect captured here; branch/jump are ignored until it is consumed
            pend_pc <= next_pc;
            state <= HOLD;
          end
        default: begin
          state <= RESET_HOLD;
          fv <= 1'b0;
        end
      endcase
    end
endmodule
